// File: rtl/mem_2r2w_pkg.sv
// Shared types and limits for the 2-read/2-write memory atom controller.
package mem_2r2w_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam int MAX_SRAM_DELAY = 8;

endpackage

// File: rtl/mem_2r2w_rdpipe.sv
// Read-valid delay line matching the attached memory's read latency (STAGES=0 passes through).
module mem_2r2w_rdpipe #(
  parameter int STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic vld_in,
  output logic vld_out
);

  localparam int DEPTH = (STAGES < 1) ? 1 : STAGES;

  logic [DEPTH-1:0] vld_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= vld_in;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // Masking with rst drops reads that were in flight when reset arrived.
  assign vld_out = ((STAGES == 0) ? vld_in : vld_p[DEPTH-1]) & ~rst;

endmodule

// File: rtl/mem_2r2w_ctrl.sv
// Init sequencer and request gate for a 2R/2W memory atom.
// Optional sticky write-collision flag: define MEM_2R2W_COLLISION_CHK_EN.
module mem_2r2w_ctrl
  import mem_2r2w_pkg::*;
#(
  parameter int NUMADDR    = 8,
  parameter int BITADDR    = 3,
  parameter int BITDATA    = 1,
  parameter int SRAM_DELAY = 0,
  parameter int RSTINIT    = 0,
  parameter int RSTSTRT    = 0,
  parameter int RSTINCR    = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ready,
  input  logic               read_0,
  input  logic [BITADDR-1:0] rd_adr_0,
  output logic               rd_vld_0,
  output logic [BITDATA-1:0] rd_dout_0,
  input  logic               read_1,
  input  logic [BITADDR-1:0] rd_adr_1,
  output logic               rd_vld_1,
  output logic [BITDATA-1:0] rd_dout_1,
  input  logic               write_2,
  input  logic [BITADDR-1:0] wr_adr_2,
  input  logic [BITDATA-1:0] wr_din_2,
  input  logic               write_3,
  input  logic [BITADDR-1:0] wr_adr_3,
  input  logic [BITDATA-1:0] wr_din_3,
  output logic               mem_read_0,
  output logic [BITADDR-1:0] mem_rd_adr_0,
  output logic               mem_read_1,
  output logic [BITADDR-1:0] mem_rd_adr_1,
  input  logic [BITDATA-1:0] mem_rd_dout_0,
  input  logic [BITDATA-1:0] mem_rd_dout_1,
  output logic               mem_write_2,
  output logic [BITADDR-1:0] mem_wr_adr_2,
  output logic [BITDATA-1:0] mem_wr_din_2,
  output logic               mem_write_3,
  output logic [BITADDR-1:0] mem_wr_adr_3,
  output logic [BITDATA-1:0] mem_wr_din_3
`ifdef MEM_2R2W_COLLISION_CHK_EN
  ,
  output logic               wr_collision
`endif
);

  localparam int DLY = (SRAM_DELAY > MAX_SRAM_DELAY) ? MAX_SRAM_DELAY : SRAM_DELAY;

  state_t             state, state_nxt;
  logic [BITADDR:0]   cnt, cnt_nxt, cnt1;
  logic               init_act;

  // Init value for word idx, wrapped to the data width.
  function automatic logic [BITDATA-1:0] init_val(input logic [BITADDR:0] idx);
    return BITDATA'(RSTSTRT + int'(idx) * RSTINCR);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (RSTINIT != 0) ? INIT : RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == INIT) begin
      cnt_nxt = cnt + (BITADDR+1)'(2);
      if (int'(cnt) + 2 >= NUMADDR) state_nxt = RUN;
    end
  end

  assign cnt1     = cnt + (BITADDR+1)'(1);
  assign init_act = (state == INIT) & ~rst;
  assign ready    = (state == RUN) & ~rst;

  assign mem_write_2  = init_act | (ready & write_2);
  assign mem_wr_adr_2 = init_act ? cnt[BITADDR-1:0] : wr_adr_2;
  assign mem_wr_din_2 = init_act ? init_val(cnt) : wr_din_2;

  // The pair is split across both write ports; odd sizes leave port 3 idle at the end.
  assign mem_write_3  = (init_act & (int'(cnt1) < NUMADDR)) | (ready & write_3);
  assign mem_wr_adr_3 = init_act ? cnt1[BITADDR-1:0] : wr_adr_3;
  assign mem_wr_din_3 = init_act ? init_val(cnt1) : wr_din_3;

  assign mem_read_0   = ready & read_0;
  assign mem_rd_adr_0 = rd_adr_0;
  assign mem_read_1   = ready & read_1;
  assign mem_rd_adr_1 = rd_adr_1;

  mem_2r2w_rdpipe #(.STAGES(DLY)) u_rdpipe_0 (
    .clk     (clk),
    .rst     (rst),
    .vld_in  (mem_read_0),
    .vld_out (rd_vld_0)
  );

  mem_2r2w_rdpipe #(.STAGES(DLY)) u_rdpipe_1 (
    .clk     (clk),
    .rst     (rst),
    .vld_in  (mem_read_1),
    .vld_out (rd_vld_1)
  );

  assign rd_dout_0 = rd_vld_0 ? mem_rd_dout_0 : '0;
  assign rd_dout_1 = rd_vld_1 ? mem_rd_dout_1 : '0;

`ifdef MEM_2R2W_COLLISION_CHK_EN
  logic coll_hit;
  assign coll_hit = ready & write_2 & write_3 & (wr_adr_2 == wr_adr_3);

  always_ff @(posedge clk) begin
    if (rst) wr_collision <= 1'b0;
    else if (coll_hit) wr_collision <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!coll_hit) else $warning("mem_2r2w_ctrl: write ports 2 and 3 hit the same address");
    end
  end
`endif

endmodule

// File: doc/mem_2r2w_ctrl.md
Name: mem_2r2w_ctrl

Overview:
- Initiator and controller for a 2-read/2-write memory atom: drives the atom's read ports 0/1 and write ports 2/3, and produces the atom's ready indication.
- After reset, sequences the memory initialisation pattern through both write ports, then passes user requests to the memory.
- Tracks read latency and returns read data with a valid strobe.
- Sits between pipeline logic and the SRAM atom in every multiport memory wrapper.

Parameters:
- NUMADDR, 8: number of memory words.
- BITADDR, 3: address width, clog2(NUMADDR).
- BITDATA, 1: data width.
- SRAM_DELAY, 0: read latency of the attached memory in cycles (0..8).
- RSTINIT, 0: 1 = write the init pattern after reset; 0 = skip init.
- RSTSTRT, 0: init value written to address 0.
- RSTINCR, 0: per-address increment of the init value.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ready  out  1  user requests accepted when high
- read_0  in  1  user read request, port 0
- rd_adr_0  in  BITADDR  user read address, port 0
- rd_vld_0  out  1  read data valid, port 0
- rd_dout_0  out  BITDATA  read data, port 0
- read_1  in  1  user read request, port 1
- rd_adr_1  in  BITADDR  user read address, port 1
- rd_vld_1  out  1  read data valid, port 1
- rd_dout_1  out  BITDATA  read data, port 1
- write_2 / wr_adr_2 / wr_din_2  in  1 / BITADDR / BITDATA  user write, port 2
- write_3 / wr_adr_3 / wr_din_3  in  1 / BITADDR / BITDATA  user write, port 3
- mem_read_0 / mem_rd_adr_0  out  1 / BITADDR  to memory
- mem_read_1 / mem_rd_adr_1  out  1 / BITADDR  to memory
- mem_rd_dout_0 / mem_rd_dout_1  in  BITDATA  from memory, valid SRAM_DELAY cycles after read
- mem_write_2 / mem_wr_adr_2 / mem_wr_din_2  out  1 / BITADDR / BITDATA  to memory
- mem_write_3 / mem_wr_adr_3 / mem_wr_din_3  out  1 / BITADDR / BITDATA  to memory

Behaviour:
- Clocking and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state is INIT if RSTINIT else RUN; init counter cnt is 0; ready, all rd_vld and all mem_* strobes are 0; the read-valid shift pipeline is cleared.
- INIT state:
  - Each cycle: mem_write_2=1, mem_wr_adr_2=cnt, mem_wr_din_2=RSTSTRT+cnt*RSTINCR.
  - mem_write_3=(cnt+1<NUMADDR), mem_wr_adr_3=cnt+1, mem_wr_din_3=RSTSTRT+(cnt+1)*RSTINCR.
  - Arithmetic is truncated to BITDATA (modulo 2^BITDATA).
  - cnt += 2. When cnt+2 >= NUMADDR, go to RUN on the next edge.
  - INIT lasts exactly ceil(NUMADDR/2) cycles. Odd NUMADDR: the last cycle uses port 2 only.
- RUN state:
  - ready=1. mem_* ports are combinational copies of the user ports, gated by ready.
  - User requests while ready=0 are dropped: no memory access, no rd_vld.
- Reads:
  - rd_vld_x is asserted exactly SRAM_DELAY cycles after an accepted read_x.
  - rd_dout_x = mem_rd_dout_x when rd_vld_x is 1, else 0.
  - SRAM_DELAY=0: rd_vld_x = read_x & ready, combinational.
- Write collision: write_2 and write_3 to the same address in the same cycle are both forwarded; the memory resolves it with port 3 winning.
- Reset mid-INIT: cnt restarts at 0 and the full sequence reruns.
- Reset in RUN: in-flight reads are discarded, with no rd_vld after reset.
- Reads and writes to the same address in the same cycle are forwarded unchanged. Read data then follows memory semantics (old data).

Optional Feature:
- MEM_2R2W_COLLISION_CHK_EN.
- With the macro: extra output wr_collision (1 bit), sticky. It sets on an accepted write_2 & write_3 with wr_adr_2==wr_adr_3, and clears only on rst. An immediate assertion also fires in simulation.
- Without the macro: the port is absent and there is no check logic.

Decomposition:
- Package mem_2r2w_pkg: state enum {INIT, RUN}, and constant MAX_SRAM_DELAY=8.
- Sub-module mem_2r2w_rdpipe: a per-port shift register of valid bits with depth SRAM_DELAY; 0 = pass-through. It is instantiated twice.

Test Plan:
- NUMADDR=8, RSTINIT=1, RSTSTRT=5, RSTINCR=3, BITDATA=4, rst low at cycle 0:
  - Cycle 0: port 2 writes addr0=5, port 3 writes addr1=8.
  - Cycle 3: port 2 writes addr6=7 (23 mod 16), port 3 writes addr7=10 (26 mod 16).
  - ready=1 from cycle 4.
- NUMADDR=5, RSTINIT=1: cycle 2 has mem_write_2=1 at addr4 and mem_write_3=0; ready at cycle 3.
- SRAM_DELAY=2, RUN: read_0 at addr3 in cycle 10 -> rd_vld_0=1 in cycle 12 only, rd_dout_0 equals memory addr3. Back-to-back reads in cycles 10-13 -> rd_vld_0 high in cycles 12-15.
- Reads and writes asserted during INIT -> no mem_read strobes, no rd_vld, and the init pattern is unaffected.
- rst pulsed at INIT cycle 2 -> cnt restarts; ready rises ceil(NUMADDR/2) cycles after rst falls. rst pulsed with 2 reads in flight -> no rd_vld.
- MEM_2R2W_COLLISION_CHK_EN defined, write_2 and write_3 both to addr5 -> wr_collision=1 next cycle and stays 1 until rst; memory addr5 holds wr_din_3.
